sn_prob_serializer: RTL and testbench

Parallel-to-serial transmitter for 9-bit stochastic-number probability words. It produces the single-pin serial framing that the multiplier's serial input deserializers consume: 9 data bits LSB-first, one tail slot, then an inter-frame gap. It sits on the test/driver side of the multiplier input pins (`ui_in[0]`/`ui_in[1]`), and is also used to stream computed `average` results back out over one pin.

---
 rtl/sn_prob_serializer.sv | 151 +++++++++++++++
 tb/tb_sn_prob_serializer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sn_prob_serializer.sv
// sn_prob_serializer: parallel-to-serial transmitter for stochastic-number
// probability words. Each frame is DATA_W data slots (LSB first), one tail
// slot, then GAP_CYCLES idle cycles before the next word can be accepted.
// Optional build macro: SN_SER_PARITY_EN -- the tail slot carries even parity
// of the captured word instead of a constant 0.
// rst_n is an asynchronous, active-high reset (the name is historical).
module sn_prob_serializer #(
    parameter int DATA_W     = 9,
    parameter int GAP_CYCLES = 131068
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_load_valid,
    output logic              o_load_ready,
    output logic              o_ser_out,
    output logic              o_ser_frame,
    output logic              o_busy,
    output logic              o_frame_done
);

    // Counter widths are clamped to at least one bit so that degenerate
    // parameter values (DATA_W = 1, GAP_CYCLES = 0) still elaborate.
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic [DATA_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              w_tail_bit;

`ifdef SN_SER_PARITY_EN
    logic              r_parity;

    // Even parity of the word, frozen at accept so later changes on
    // i_load_data cannot disturb the tail slot.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^i_load_data;
        end
    end

    assign w_tail_bit = r_parity;
`else
    assign w_tail_bit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and outputs; outputs are decoded from registered
    // state only, so i_load_valid never reaches an output combinationally.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        o_load_ready = 1'b0;
        o_busy       = 1'b1;
        o_ser_out    = 1'b0;
        o_ser_frame  = 1'b0;
        o_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_load_ready = 1'b1;
                o_busy       = 1'b0;
                if (i_load_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                o_ser_out   = r_shift[0];
                o_ser_frame = 1'b1;
                if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
                    w_state_next = ST_TAIL;
                end
            end
            ST_TAIL: begin
                o_frame_done = 1'b1;
                o_ser_out    = w_tail_bit;
                w_state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                // The counter holds the number of gap cycles still to run,
                // including the current one.
                if (r_gap_cnt <= GAP_W'(1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, shift during data slots, load and
    // count down the inter-frame gap.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= i_load_data;
                        r_bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= r_shift >> 1;
                    if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
                        r_bit_cnt <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_TAIL: begin
                    r_gap_cnt <= GAP_W'(GAP_CYCLES);
                end
                ST_GAP: begin
                    if (r_gap_cnt != '0) begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_gap_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sn_prob_serializer.sv
// Self-checking bench for sn_prob_serializer. Two instances share clk/rst_n:
// one with GAP_CYCLES = 4 and one with GAP_CYCLES = 0. Outputs are compared
// at the falling edge as the packed vector {ready, busy, frame, done, ser}.
module tb_sn_prob_serializer;

`ifdef SN_SER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;

    logic [8:0] a_data;
    logic       a_valid, a_ready, a_ser, a_frame, a_busy, a_done;
    logic [8:0] z_data;
    logic       z_valid, z_ready, z_ser, z_frame, z_busy, z_done;

    int checks = 0;
    int errors = 0;

    sn_prob_serializer #(.DATA_W(9), .GAP_CYCLES(4)) u_dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load_data  (a_data),
        .i_load_valid (a_valid),
        .o_load_ready (a_ready),
        .o_ser_out    (a_ser),
        .o_ser_frame  (a_frame),
        .o_busy       (a_busy),
        .o_frame_done (a_done)
    );

    sn_prob_serializer #(.DATA_W(9), .GAP_CYCLES(0)) u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load_data  (z_data),
        .i_load_valid (z_valid),
        .o_load_ready (z_ready),
        .o_ser_out    (z_ser),
        .o_ser_frame  (z_frame),
        .o_busy       (z_busy),
        .o_frame_done (z_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // seq lists the expected serial bits in transmit order: seq[8] goes first.
    typedef struct {
        string      tag;
        logic [8:0] data;
        logic [8:0] seq;
        logic       par;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [4:0] outs(input int gap);
        if (gap == 0) return {z_ready, z_busy, z_frame, z_done, z_ser};
        return {a_ready, a_busy, a_frame, a_done, a_ser};
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {rdy,busy,frm,done,ser}=%b required %b", name, act, exp);
        end
    endtask

    task automatic set_in(input int gap, input logic v, input logic [8:0] d);
        if (gap == 0) begin
            z_valid = v;
            z_data  = d;
        end else begin
            a_valid = v;
            a_data  = d;
        end
    endtask

    // Called at a falling edge while the instance is idle: check idle, offer a word.
    task automatic drive_accept(input int gap, input string tag, input logic [8:0] d);
        chk({tag, "_idle"}, outs(gap), 5'b10000);
        set_in(gap, 1'b1, d);
    endtask

    // Follows one frame after an accept edge; at the first slot the inputs are
    // replaced by (nv, nd). Ends at the falling edge where load_ready is back.
    task automatic check_frame(input int gap, input string tag, input logic [8:0] seq,
                               input logic tail, input logic nv, input logic [8:0] nd);
        logic [4:0] e;
        int last;
        last = 11 + gap;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) set_in(gap, nv, nd);
            if (c <= 9)        e = {3'b011, 1'b0, seq[9-c]};
            else if (c == 10)  e = {3'b010, 1'b1, tail};
            else if (c < last) e = 5'b01000;
            else               e = 5'b10000;
            chk($sformatf("%s_c%0d", tag, c), outs(gap), e);
        end
        $display("txn %s gap=%0d frame of %0d cycles checked", tag, gap, last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{tag: "t1A5", data: 9'h1A5, seq: 9'b101001011, par: 1'b1};
        vecs[1] = '{tag: "t003", data: 9'h003, seq: 9'b110000000, par: 1'b0};
        vecs[2] = '{tag: "t0AA", data: 9'h0AA, seq: 9'b010101010, par: 1'b0};
        vecs[3] = '{tag: "t1FF", data: 9'h1FF, seq: 9'b111111111, par: 1'b1};

        rst_n   = 1'b1;
        a_valid = 1'b0;
        a_data  = '0;
        z_valid = 1'b0;
        z_data  = '0;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_a%0d", i), outs(4), 5'b10000);
            chk($sformatf("rst_z%0d", i), outs(0), 5'b10000);
        end
        rst_n = 1'b0;
        $display("txn reset released");

        // Table-driven single frames, GAP_CYCLES = 4; data changes after accept.
        for (int i = 0; i < 4; i++) begin
            drive_accept(4, vecs[i].tag, vecs[i].data);
            check_frame(4, vecs[i].tag, vecs[i].seq, PAR_EN ? vecs[i].par : 1'b0,
                        1'b0, vecs[i].data ^ 9'h1FF);
        end

        // Busy rejection: 0FF held valid while 100 is in flight.
        drive_accept(4, "b100", 9'h100);
        check_frame(4, "b100", 9'b000000001, PAR_EN ? 1'b1 : 1'b0, 1'b1, 9'h0FF);
        check_frame(4, "b0FF", 9'b111111110, 1'b0, 1'b0, 9'h000);

        // Reset during data slot 5 of 1FF.
        drive_accept(4, "r1FF", 9'h1FF);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) set_in(4, 1'b0, 9'h000);
            chk($sformatf("r1FF_c%0d", c), outs(4), 5'b01101);
        end
        #2 rst_n = 1'b1;
        #1 chk("rst_async", outs(4), 5'b10000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_hold%0d", i), outs(4), 5'b10000);
        end
        rst_n = 1'b0;
        $display("txn mid-frame reset");
        drive_accept(4, "r001", 9'h001);
        check_frame(4, "r001", 9'b100000000, PAR_EN ? 1'b1 : 1'b0, 1'b0, 9'h1FE);

        // GAP_CYCLES = 0 back-to-back with valid held.
        drive_accept(0, "z155", 9'h155);
        check_frame(0, "z155", 9'b101010101, PAR_EN ? 1'b1 : 1'b0, 1'b1, 9'h0AA);
        check_frame(0, "z0AA", 9'b010101010, 1'b0, 1'b0, 9'h000);

        @(negedge clk);
        chk("final_a", outs(4), 5'b10000);
        chk("final_z", outs(0), 5'b10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
